// File: rtl/instruction_fetcher_pkg.sv
// ============================================================================
// instruction_fetcher_pkg
// Shared fetch-side types and defaults for the instruction fetcher.
// Revision: 1.0
// ============================================================================
`default_nettype none

package instruction_fetcher_pkg;

  localparam int          DEFAULT_ADDR_WIDTH = 32;
  localparam int          DEFAULT_INST_WIDTH = 32;
  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;

  typedef logic [DEFAULT_ADDR_WIDTH-1:0] addr_t;
  typedef logic [DEFAULT_INST_WIDTH-1:0] inst_t;

endpackage

`default_nettype wire

// File: rtl/instruction_fetcher.sv
// ============================================================================
// instruction_fetcher
// Holds the fetch PC, queries the predictor, requests the icache and pushes
// fetched instructions (with PC and predicted next PC) into the IQ.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instruction_fetcher
  import instruction_fetcher_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int                    INST_WIDTH = DEFAULT_INST_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  clr_in,
  input  logic [ADDR_WIDTH-1:0] rob_to_if_alt_PC,
  output logic [ADDR_WIDTH-1:0] if_to_pr_PC,
  input  logic [ADDR_WIDTH-1:0] pr_to_if_predict_PC,
  output logic                  if_to_ic_en,
  output logic [ADDR_WIDTH-1:0] if_to_ic_PC,
  input  logic                  ic_to_if_ready,
  input  logic [INST_WIDTH-1:0] ic_to_if_inst,
  input  logic                  iq_to_if_full,
  output logic                  if_to_iq_valid,
  output logic [INST_WIDTH-1:0] if_to_iq_inst,
  output logic [ADDR_WIDTH-1:0] if_to_iq_PC,
  output logic [ADDR_WIDTH-1:0] if_to_iq_pred_PC
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [INST_WIDTH-1:0] r_hold_inst;
  logic [ADDR_WIDTH-1:0] r_hold_pc;
  logic [ADDR_WIDTH-1:0] r_hold_pred;

  assign if_to_pr_PC = r_pc;
  assign if_to_ic_PC = r_pc;
  assign if_to_ic_en = (r_state == FETCH) && !rst_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state          <= FETCH;
      r_pc             <= RESET_PC;
      r_hold_inst      <= '0;
      r_hold_pc        <= '0;
      r_hold_pred      <= '0;
      if_to_iq_valid   <= 1'b0;
      if_to_iq_inst    <= '0;
      if_to_iq_PC      <= '0;
      if_to_iq_pred_PC <= '0;
    end else if (rdy_in) begin
      if (clr_in) begin
        // Redirect wins over any same-cycle icache response; the held entry
        // is dropped simply by leaving HOLD.
        r_state        <= FLUSH;
        r_pc           <= rob_to_if_alt_PC;
        if_to_iq_valid <= 1'b0;
      end else begin
        case (r_state)
          FETCH: begin
            if (ic_to_if_ready && !iq_to_if_full) begin
              if_to_iq_valid   <= 1'b1;
              if_to_iq_inst    <= ic_to_if_inst;
              if_to_iq_PC      <= r_pc;
              if_to_iq_pred_PC <= pr_to_if_predict_PC;
              r_pc             <= pr_to_if_predict_PC;
            end else if (ic_to_if_ready) begin
              r_hold_inst    <= ic_to_if_inst;
              r_hold_pc      <= r_pc;
              r_hold_pred    <= pr_to_if_predict_PC;
              r_state        <= HOLD;
              if_to_iq_valid <= 1'b0;
            end else begin
              if_to_iq_valid <= 1'b0;
            end
          end
          HOLD: begin
            if (!iq_to_if_full) begin
              if_to_iq_valid   <= 1'b1;
              if_to_iq_inst    <= r_hold_inst;
              if_to_iq_PC      <= r_hold_pc;
              if_to_iq_pred_PC <= r_hold_pred;
              r_pc             <= r_hold_pred;
              r_state          <= FETCH;
            end else begin
              if_to_iq_valid <= 1'b0;
            end
          end
          FLUSH: begin
            // One idle cycle with the request dropped lets the icache abandon
            // whatever it had in flight for the old PC.
            if_to_iq_valid <= 1'b0;
            r_state        <= FETCH;
          end
          default: begin
            if_to_iq_valid <= 1'b0;
            r_state        <= FETCH;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetcher.sv
// ============================================================================
// tb_instruction_fetcher
// Directed bench with a push scoreboard for instruction_fetcher.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instruction_fetcher;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pred;
  } entry_t;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clr_in;
  logic [31:0] rob_to_if_alt_PC;
  logic [31:0] if_to_pr_PC;
  logic [31:0] pr_to_if_predict_PC;
  logic        if_to_ic_en;
  logic [31:0] if_to_ic_PC;
  logic        ic_to_if_ready;
  logic [31:0] ic_to_if_inst;
  logic        iq_to_if_full;
  logic        if_to_iq_valid;
  logic [31:0] if_to_iq_inst;
  logic [31:0] if_to_iq_PC;
  logic [31:0] if_to_iq_pred_PC;

  logic        ovr_en;
  logic [31:0] ovr_pc;

  int     checks = 0;
  int     errors = 0;
  entry_t sb[$];

  always #5 clk_in = ~clk_in;

  // Predictor stand-in: sequential next PC unless a directed target is forced.
  always_comb pr_to_if_predict_PC = ovr_en ? ovr_pc : if_to_pr_PC + 32'd4;

  instruction_fetcher dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .rdy_in              (rdy_in),
    .clr_in              (clr_in),
    .rob_to_if_alt_PC    (rob_to_if_alt_PC),
    .if_to_pr_PC         (if_to_pr_PC),
    .pr_to_if_predict_PC (pr_to_if_predict_PC),
    .if_to_ic_en         (if_to_ic_en),
    .if_to_ic_PC         (if_to_ic_PC),
    .ic_to_if_ready      (ic_to_if_ready),
    .ic_to_if_inst       (ic_to_if_inst),
    .iq_to_if_full       (iq_to_if_full),
    .if_to_iq_valid      (if_to_iq_valid),
    .if_to_iq_inst       (if_to_iq_inst),
    .if_to_iq_PC         (if_to_iq_PC),
    .if_to_iq_pred_PC    (if_to_iq_pred_PC)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #2;
  endtask

  task automatic expect_push(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] pred);
    entry_t e;
    e.inst = inst;
    e.pc   = pc;
    e.pred = pred;
    sb.push_back(e);
  endtask

  // The IQ accepts at the next rising edge whenever valid and rdy_in are high.
  always @(negedge clk_in) begin
    if (!rst_in && rdy_in && if_to_iq_valid === 1'b1) begin
      check("push_was_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        entry_t e;
        e = sb.pop_front();
        check("push_inst", if_to_iq_inst, e.inst);
        check("push_pc", if_to_iq_PC, e.pc);
        check("push_pred", if_to_iq_pred_PC, e.pred);
      end
    end
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clr_in = 1'b0; rob_to_if_alt_PC = '0;
    ic_to_if_ready = 1'b0; ic_to_if_inst = '0; iq_to_if_full = 1'b0;
    ovr_en = 1'b0; ovr_pc = '0;

    // Reset state
    step(); step();
    check("rst_en", 32'(if_to_ic_en), 32'd0);
    check("rst_valid", 32'(if_to_iq_valid), 32'd0);
    check("rst_iq_pc", if_to_iq_PC, 32'h0);
    check("rst_pc", if_to_pr_PC, 32'h0);
    rst_in = 1'b0;
    #1;
    check("rel_en", 32'(if_to_ic_en), 32'd1);

    // Back-to-back responses at PC 0 and 4
    ic_to_if_ready = 1'b1; ic_to_if_inst = 32'h0000_0013;
    expect_push(32'h0000_0013, 32'h0, 32'h4);
    step();
    expect_push(32'h0000_0013, 32'h4, 32'h8);
    step();
    ic_to_if_ready = 1'b0;
    check("b2b_pc", if_to_pr_PC, 32'h8);
    step();

    // Redirect to 0x10, then response there while the IQ is full
    ovr_en = 1'b1; ovr_pc = 32'h10; ic_to_if_ready = 1'b1; ic_to_if_inst = 32'hAAAA_0001;
    expect_push(32'hAAAA_0001, 32'h8, 32'h10);
    step();
    ovr_pc = 32'h40; iq_to_if_full = 1'b1; ic_to_if_inst = 32'hBBBB_0002;
    step();
    ic_to_if_ready = 1'b0;
    check("hold_en_1", 32'(if_to_ic_en), 32'd0);
    step();
    check("hold_en_2", 32'(if_to_ic_en), 32'd0);
    check("hold_valid", 32'(if_to_iq_valid), 32'd0);
    step();
    iq_to_if_full = 1'b0;
    expect_push(32'hBBBB_0002, 32'h10, 32'h40);
    check("hold_en_3", 32'(if_to_ic_en), 32'd0);
    step();
    ovr_en = 1'b0;
    check("hold_resume_pc", if_to_ic_PC, 32'h40);
    check("hold_resume_en", 32'(if_to_ic_en), 32'd1);

    // Clear coinciding with an icache response
    clr_in = 1'b1; rob_to_if_alt_PC = 32'h200; ic_to_if_ready = 1'b1; ic_to_if_inst = 32'hDEAD_0003;
    step();
    clr_in = 1'b0;
    check("flush_en", 32'(if_to_ic_en), 32'd0);
    check("flush_pc", if_to_ic_PC, 32'h200);
    check("flush_valid", 32'(if_to_iq_valid), 32'd0);
    step();
    ic_to_if_ready = 1'b0;
    check("post_flush_en", 32'(if_to_ic_en), 32'd1);
    check("post_flush_pc", if_to_ic_PC, 32'h200);
    step();
    check("flush_ready_ignored_pc", if_to_ic_PC, 32'h200);

    // Clear while holding an entry
    ic_to_if_ready = 1'b1; iq_to_if_full = 1'b1; ic_to_if_inst = 32'hCCCC_0004;
    step();
    ic_to_if_ready = 1'b0; clr_in = 1'b1; rob_to_if_alt_PC = 32'h300;
    check("hold2_en", 32'(if_to_ic_en), 32'd0);
    step();
    clr_in = 1'b0; iq_to_if_full = 1'b0;
    check("hold_clr_en", 32'(if_to_ic_en), 32'd0);
    check("hold_clr_pc", if_to_ic_PC, 32'h300);
    step();
    check("hold_clr_resume_en", 32'(if_to_ic_en), 32'd1);
    check("hold_clr_resume_pc", if_to_ic_PC, 32'h300);

    // Freeze right after a push; icache keeps pulsing ready meanwhile
    ic_to_if_ready = 1'b1; ic_to_if_inst = 32'hD00D_0005;
    expect_push(32'hD00D_0005, 32'h300, 32'h304);
    step();
    rdy_in = 1'b0;
    check("frz_valid_0", 32'(if_to_iq_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("frz_valid", 32'(if_to_iq_valid), 32'd1);
      check("frz_pc", if_to_ic_PC, 32'h304);
      check("frz_en", 32'(if_to_ic_en), 32'd1);
    end
    rdy_in = 1'b1; ic_to_if_ready = 1'b0;
    step();
    check("unfrz_valid", 32'(if_to_iq_valid), 32'd0);
    check("unfrz_pc", if_to_ic_PC, 32'h304);

    // Reset in the middle of HOLD
    ic_to_if_ready = 1'b1; iq_to_if_full = 1'b1; ic_to_if_inst = 32'hEEEE_0006;
    step();
    ic_to_if_ready = 1'b0; rst_in = 1'b1;
    step();
    check("mid_rst_valid", 32'(if_to_iq_valid), 32'd0);
    check("mid_rst_pc", if_to_ic_PC, 32'h0);
    check("mid_rst_en", 32'(if_to_ic_en), 32'd0);
    rst_in = 1'b0; iq_to_if_full = 1'b0;
    #1;
    check("mid_rst_rel_en", 32'(if_to_ic_en), 32'd1);
    step(); step();
    check("mid_rst_pc_hold", if_to_ic_PC, 32'h0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
